alu_adder_sequencer: RTL and testbench

Multi-cycle adder/subtractor controller that computes a WIDTH-bit sum by driving one 4-bit `alu_adder_half` one nibble per cycle, LSB nibble first, chaining the carry through a register. It sits between the ALU issue logic and the nibble adder, so the 4-bit datapath can serve 8/16/32-bit operations. The handshake is start/busy/done, and results are held until the next operation.

---
 rtl/alu_pkg.sv | 12 +
 rtl/alu_adder_half.sv | 26 ++
 rtl/alu_adder_sequencer.sv | 121 ++++++++++++
 tb/tb_alu_adder_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial adder sequencer.
package alu_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_adder_half.sv
// 4-bit combinational adder slice; outputs are forced to zero when not enabled.
module alu_adder_half
  import alu_pkg::*;
(
  input  logic                en,
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W:0] total;

  // Full-width nibble add including carry; gated by enable.
  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
    if (!en) begin
      total = '0;
    end
  end

  assign sum  = total[NIBBLE_W-1:0];
  assign cout = total[NIBBLE_W];

endmodule

// File: rtl/alu_adder_sequencer.sv
// WIDTH-bit add/subtract built from one 4-bit slice, one nibble per cycle, LSB first.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; last result held
// RUN   | one nibble added per cycle, carry chained through carry_q
// DONE  | result valid, done pulsed; a start here is accepted directly
module alu_adder_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < 8)) begin : g_bad_width
    $error("alu_adder_sequencer: WIDTH must be a multiple of 4 and at least 8");
  end

  seq_state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NIBBLES-1:0][NIBBLE_W-1:0] a_q, a_d;
  logic [NIBBLES-1:0][NIBBLE_W-1:0] beff_q, beff_d;
  logic [NIBBLES-1:0][NIBBLE_W-1:0] result_q, result_d;
  logic carry_q, carry_d;

  logic                nib_en;
  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_cout;

  alu_adder_half u_half (
    .en   (nib_en),
    .a    (a_q[idx_q]),
    .b    (beff_q[idx_q]),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // Next-state: accept operands in IDLE/DONE, step one nibble per cycle in RUN.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    beff_d   = beff_q;
    result_d = result_q;
    carry_d  = carry_q;
    nib_en   = 1'b0;
    case (state_q)
      RUN: begin
        nib_en          = 1'b1;
        result_d[idx_q] = nib_sum;
        carry_d         = nib_cout;
        idx_d           = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DONE;
        end
      end
      IDLE, DONE: begin
        if (start) begin
          a_d      = a;
          beff_d   = sub ? ~b : b;
          carry_d  = carry_in;
          result_d = '0;
          idx_d    = '0;
          state_d  = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      beff_q   <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      beff_q   <= beff_d;
      result_q <= result_d;
      carry_q  <= carry_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign carry_out = carry_q;
  // Flags are decoded from held registers; overflow is suppressed while nibbles are in flight.
  assign overflow  = (state_q != RUN)
                   && (a_q[NIBBLES-1][NIBBLE_W-1] == beff_q[NIBBLES-1][NIBBLE_W-1])
                   && (result_q[NIBBLES-1][NIBBLE_W-1] != a_q[NIBBLES-1][NIBBLE_W-1]);
  assign zero      = (result_q == '0);

endmodule

// File: tb/tb_alu_adder_sequencer.sv
// Bench for the nibble-serial adder: WIDTH=16 and WIDTH=8 instances against a word-level model.
module tb_alu_adder_sequencer;

  logic        clk;
  logic        reset;
  logic        start16, start8;
  logic        sub;
  logic        carry_in;
  logic [15:0] a, b;

  logic        busy16, done16, co16, ov16, z16;
  logic [15:0] res16;
  logic        busy8, done8, co8, ov8, z8;
  logic [7:0]  res8;

  int total = 0;
  int bad   = 0;

  alu_adder_sequencer #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .sub(sub), .a(a), .b(b),
    .carry_in(carry_in), .busy(busy16), .done(done16), .result(res16),
    .carry_out(co16), .overflow(ov16), .zero(z16)
  );

  alu_adder_sequencer #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .sub(sub), .a(a[7:0]), .b(b[7:0]),
    .carry_in(carry_in), .busy(busy8), .done(done8), .result(res8),
    .carry_out(co8), .overflow(ov8), .zero(z8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word-level reference: a + (sub ? ~b : b) + cin over w bits.
  task automatic model(input int w, input logic [31:0] av, input logic [31:0] bv,
                       input logic sv, input logic cv,
                       output logic [31:0] res, output logic co, output logic ov,
                       output logic z);
    longint mask, bb, s;
    mask = (longint'(1) << w) - 1;
    bb   = sv ? (~longint'(bv) & mask) : (longint'(bv) & mask);
    s    = (longint'(av) & mask) + bb + longint'(cv);
    res  = 32'(s & mask);
    co   = s[w];
    ov   = (av[w-1] == bb[w-1]) && (res[w-1] != av[w-1]);
    z    = (res == 0);
  endtask

  task automatic outs(input int w, output logic bz, output logic dn, output logic [31:0] r,
                      output logic co, output logic ov, output logic z);
    if (w == 16) begin
      bz = busy16; dn = done16; r = {16'h0, res16}; co = co16; ov = ov16; z = z16;
    end else begin
      bz = busy8; dn = done8; r = {24'h0, res8}; co = co8; ov = ov8; z = z8;
    end
  endtask

  task automatic check_reset_vals(input int w, input string tag);
    logic bz, dn, co, ov, z;
    logic [31:0] r;
    outs(w, bz, dn, r, co, ov, z);
    chk({tag, "_busy"}, 32'(bz), 0);
    chk({tag, "_done"}, 32'(dn), 0);
    chk({tag, "_result"}, r, 0);
    chk({tag, "_carry"}, 32'(co), 0);
    chk({tag, "_ovf"}, 32'(ov), 0);
    chk({tag, "_zero"}, 32'(z), 1);
  endtask

  task automatic check_result(input int w, input string tag, input logic [31:0] av,
                              input logic [31:0] bv, input logic sv, input logic cv);
    logic bz, dn, co, ov, z, eco, eov, ez;
    logic [31:0] r, er;
    model(w, av, bv, sv, cv, er, eco, eov, ez);
    outs(w, bz, dn, r, co, ov, z);
    chk({tag, "_result"}, r, er);
    chk({tag, "_carry"}, 32'(co), 32'(eco));
    chk({tag, "_ovf"}, 32'(ov), 32'(eov));
    chk({tag, "_zero"}, 32'(z), 32'(ez));
  endtask

  // Caller is positioned 1 time unit after a rising edge.
  task automatic run_op(input int w, input string tag, input logic [15:0] av,
                        input logic [15:0] bv, input logic sv, input logic cv);
    logic bz, dn, co, ov, z;
    logic [31:0] r;
    int n;
    a = av; b = bv; sub = sv; carry_in = cv;
    if (w == 16) start16 = 1'b1; else start8 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0; start8 = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    outs(w, bz, dn, r, co, ov, z);
    chk({tag, "_busy"}, 32'(bz), 1);
    n = 0;
    dn = 1'b0;
    while (!dn && n < 20) begin
      @(posedge clk); #1;
      n++;
      outs(w, bz, dn, r, co, ov, z);
    end
    chk({tag, "_latency"}, n, w / 4);
    if (w == 16) check_result(w, tag, {16'h0, av}, {16'h0, bv}, sv, cv);
    else check_result(w, tag, {24'h0, av[7:0]}, {24'h0, bv[7:0]}, sv, cv);
    @(posedge clk); #1;
    outs(w, bz, dn, r, co, ov, z);
    chk({tag, "_done_pulse"}, 32'(dn), 0);
  endtask

  initial begin
    int n, cnt, first;
    reset = 1'b1; start16 = 1'b0; start8 = 1'b0;
    sub = 1'b0; carry_in = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals(16, "rst16");
    check_reset_vals(8, "rst8");
    reset = 1'b0;

    run_op(16, "add_5555", 16'h1234, 16'h4321, 1'b0, 1'b0);
    chk("add_5555_exact", {16'h0, res16}, 32'h5555);
    run_op(16, "ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    chk("ripple_exact", {31'h0, co16}, 1);
    run_op(16, "sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1);
    chk("sub_borrow_exact", {16'h0, res16}, 32'hFFFE);
    run_op(16, "ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    chk("ovf_pos_exact", {31'h0, ov16}, 1);

    // Start pulsed mid-RUN must be ignored.
    a = 16'h00F0; b = 16'h0F00; sub = 1'b0; carry_in = 1'b0; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    cnt = 0; first = 0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 3) begin a = 16'h0001; b = 16'h0001; start16 = 1'b1; end
      @(posedge clk); #1;
      if (k == 3) start16 = 1'b0;
      if (done16) begin cnt++; if (first == 0) first = k; end
    end
    chk("ignore_done_count", cnt, 1);
    chk("ignore_latency", first, 4);
    chk("ignore_result", {16'h0, res16}, 32'h0FF0);

    // Start held through DONE: back-to-back acceptance.
    a = 16'h1111; b = 16'h2222; sub = 1'b0; carry_in = 1'b1; start16 = 1'b1;
    @(posedge clk); #1;
    a = 16'h8000; b = 16'h8000; carry_in = 1'b0;
    n = 0;
    while (!done16 && n < 20) begin @(posedge clk); #1; n++; end
    chk("b2b_first_latency", n, 4);
    check_result(16, "b2b_first", 32'h1111, 32'h2222, 1'b0, 1'b1);
    @(posedge clk); #1;
    start16 = 1'b0;
    chk("b2b_accept_busy", {31'h0, busy16}, 1);
    chk("b2b_accept_done", {31'h0, done16}, 0);
    n = 0;
    while (!done16 && n < 20) begin @(posedge clk); #1; n++; end
    chk("b2b_second_latency", n, 4);
    check_result(16, "b2b_second", 32'h8000, 32'h8000, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Reset mid-RUN at idx=2.
    a = 16'h1234; b = 16'h1111; sub = 1'b0; carry_in = 1'b0; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_vals(16, "midrst");
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done16) cnt++;
    end
    chk("midrst_no_done", cnt, 0);
    run_op(16, "after_rst", 16'hA5A5, 16'h5A5A, 1'b0, 1'b1);

    run_op(8, "w8_ovf", 16'h0080, 16'h0080, 1'b0, 1'b0);
    chk("w8_ovf_exact", {24'h0, res8}, 32'h00);

    for (int i = 0; i < 25; i++) begin
      run_op(16, "rnd16", 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      run_op(8, "rnd8", 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
